// File: rtl/reg_sb_pkg.sv
// ----------------------------------------------------------------------------
// reg_sb_pkg
// Shared definitions for the register dependency scoreboard (producer side).
//   - operand size codes (SZ_BYTE / SZ_WORD / SZ_DWORD, 2'b11 reserved)
//   - GPR byte-lane index constants within a 3-bit per-register lane group
//   - sb_entry_t : one pipeline scoreboard entry {v, gpr, seg, mm}
//   - gpr_lane_encode : destination id/size -> pending GPR byte-lane vector
//   - reg_onehot8     : register id -> one-hot pending vector (SEG / MMX)
// No ports (package).
// ----------------------------------------------------------------------------
package reg_sb_pkg;

    localparam int unsigned NUM_GPR = 8;
    localparam int unsigned NUM_SEG = 8;
    localparam int unsigned NUM_MM  = 8;
    localparam int unsigned GPR_W   = 3 * NUM_GPR;

    // Lane offsets inside the 3-bit group that belongs to one GPR
    localparam int unsigned LANE_BYTE0 = 0;   // bits 7:0
    localparam int unsigned LANE_BYTE1 = 1;   // bits 15:8
    localparam int unsigned LANE_HIGH  = 2;   // bits 31:16

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_WORD  = 2'b01,
        SZ_DWORD = 2'b10,
        SZ_RSVD  = 2'b11
    } size_e;

    typedef struct packed {
        logic             v;
        logic [GPR_W-1:0] gpr;
        logic [NUM_SEG-1:0] seg;
        logic [NUM_MM-1:0]  mm;
    } sb_entry_t;

    // Byte writes to ids 4-7 target the high byte (bits 15:8) of GPR id-4,
    // so they land on lane 1 of that register's group rather than lane 0.
    function automatic logic [GPR_W-1:0] gpr_lane_encode(input logic [2:0] id,
                                                         input logic [1:0] size);
        logic [GPR_W-1:0] lanes_v;
        int unsigned      base_v;
        int unsigned      lo_base_v;
        base_v    = 32'd3 * 32'(id);
        lo_base_v = 32'd3 * 32'(id[1:0]);
        lanes_v   = '0;
        case (size_e'(size))
            SZ_BYTE: begin
                if (id[2]) begin
                    lanes_v = 24'h000001 << (lo_base_v + LANE_BYTE1);
                end else begin
                    lanes_v = 24'h000001 << (lo_base_v + LANE_BYTE0);
                end
            end
            SZ_WORD:  lanes_v = 24'h000003 << base_v;
            SZ_DWORD: lanes_v = 24'h000007 << base_v;
            default:  lanes_v = 24'h000000;
        endcase
        return lanes_v;
    endfunction

    function automatic logic [7:0] reg_onehot8(input logic [2:0] id);
        return 8'h01 << id;
    endfunction

endpackage

// File: rtl/reg_scoreboard_gen_if.sv
// ----------------------------------------------------------------------------
// reg_scoreboard_gen_if
// Bundles the AG destination info, pipeline control and scoreboard outputs.
//   master : AG stage / pipeline control (drives destinations, stalls, flush)
//   slave  : reg_scoreboard_gen (drives stage valids and scoreboard vectors)
// Optional macro SB_WB_STAGE_EN adds wb_stall, wb_v and WB scoreboard vectors.
// ----------------------------------------------------------------------------
interface reg_scoreboard_gen_if;

    logic        flush;
    logic        ag_v;
    logic        dr1_wr;
    logic [2:0]  dr1_id;
    logic [1:0]  dr1_size;
    logic        dr2_wr;
    logic [2:0]  dr2_id;
    logic [1:0]  dr2_size;
    logic        seg_wr;
    logic [2:0]  seg_id;
    logic        mm_wr;
    logic [2:0]  mm_id;
    logic        ex_stall;
    logic        me_stall;

    logic        ex_v;
    logic        me_v;
    logic [23:0] ex_gpr_scoreboard;
    logic [23:0] me_gpr_scoreboard;
    logic [7:0]  ex_seg_scoreboard;
    logic [7:0]  me_seg_scoreboard;
    logic [7:0]  ex_mm_scoreboard;
    logic [7:0]  me_mm_scoreboard;
`ifdef SB_WB_STAGE_EN
    logic        wb_stall;
    logic        wb_v;
    logic [23:0] wb_gpr_scoreboard;
    logic [7:0]  wb_seg_scoreboard;
    logic [7:0]  wb_mm_scoreboard;
`endif

    modport master (
        output flush, ag_v,
        output dr1_wr, dr1_id, dr1_size, dr2_wr, dr2_id, dr2_size,
        output seg_wr, seg_id, mm_wr, mm_id,
        output ex_stall, me_stall,
`ifdef SB_WB_STAGE_EN
        output wb_stall,
        input  wb_v, wb_gpr_scoreboard, wb_seg_scoreboard, wb_mm_scoreboard,
`endif
        input  ex_v, me_v,
        input  ex_gpr_scoreboard, me_gpr_scoreboard,
        input  ex_seg_scoreboard, me_seg_scoreboard,
        input  ex_mm_scoreboard, me_mm_scoreboard
    );

    modport slave (
        input  flush, ag_v,
        input  dr1_wr, dr1_id, dr1_size, dr2_wr, dr2_id, dr2_size,
        input  seg_wr, seg_id, mm_wr, mm_id,
        input  ex_stall, me_stall,
`ifdef SB_WB_STAGE_EN
        input  wb_stall,
        output wb_v, wb_gpr_scoreboard, wb_seg_scoreboard, wb_mm_scoreboard,
`endif
        output ex_v, me_v,
        output ex_gpr_scoreboard, me_gpr_scoreboard,
        output ex_seg_scoreboard, me_seg_scoreboard,
        output ex_mm_scoreboard, me_mm_scoreboard
    );

endinterface

// File: rtl/reg_scoreboard_gen_chk.sv
// ----------------------------------------------------------------------------
// reg_scoreboard_gen_chk
// Protocol checker for the scoreboard pipeline control.
//   clk, rst_n : clock, async active-low reset
//   ex_stall   : EX stall input of the scoreboard
//   me_stall   : ME stall input of the scoreboard
//   viol_cnt   : saturating count of cycles with me_stall && !ex_stall
// FATAL_ON_VIOLATION selects whether a violation is also reported as an error.
// ----------------------------------------------------------------------------
module reg_scoreboard_gen_chk #(
    parameter bit FATAL_ON_VIOLATION = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ex_stall,
    input  logic       me_stall,
    output logic [7:0] viol_cnt
);

    logic       illegal_s;
    logic [7:0] viol_cnt_r;

    assign illegal_s = me_stall & ~ex_stall;

    // Saturating count of illegal stall combinations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_cnt_r <= 8'd0;
        end else if (illegal_s && (viol_cnt_r != 8'hFF)) begin
            viol_cnt_r <= viol_cnt_r + 8'd1;
        end else begin
            viol_cnt_r <= viol_cnt_r;
        end
    end

    assign viol_cnt = viol_cnt_r;

    // ME may only stall when EX stalls too
    a_stall_order: assert property (@(posedge clk) disable iff (!rst_n) !illegal_s)
        else begin
            if (FATAL_ON_VIOLATION) begin
                $error("reg_scoreboard_gen: me_stall asserted without ex_stall");
            end
        end

endmodule

// File: rtl/reg_scoreboard_gen_stage.sv
// ----------------------------------------------------------------------------
// sb_stage_reg
// One scoreboard pipeline entry. Priority: flush > hold > bubble > load.
//   clk, rst_n : clock, async active-low clear
//   flush      : clear entry (wins over everything)
//   hold       : keep current entry
//   bubble     : insert an empty entry
//   d / q      : next entry / registered entry
// An empty entry is all-zero, so downstream consumers need no valid gating.
// ----------------------------------------------------------------------------
module sb_stage_reg
    import reg_sb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      flush,
    input  logic      hold,
    input  logic      bubble,
    input  sb_entry_t d,
    output sb_entry_t q
);

    sb_entry_t entry_r;

    // Entry register with flush/hold/bubble/load priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_r <= '0;
        end else if (flush) begin
            entry_r <= '0;
        end else if (hold) begin
            entry_r <= entry_r;
        end else if (bubble) begin
            entry_r <= '0;
        end else begin
            entry_r <= d;
        end
    end

    assign q = entry_r;

endmodule

// File: rtl/reg_scoreboard_gen.sv
// ----------------------------------------------------------------------------
// reg_scoreboard_gen
// Producer side of the register dependency interlock. Encodes the AG-stage
// destination registers into GPR byte-lane / SEG / MMX pending vectors and
// pipes them through EX and ME scoreboard entries in lock-step with the
// datapath. Entries retire by advancing out of the last stage.
//   clk   : core clock
//   rst_n : async active-low reset
//   sb    : reg_scoreboard_gen_if.slave (AG inputs, flush, stalls,
//           EX/ME valids and scoreboard vectors)
// Optional macro SB_WB_STAGE_EN: adds a WB entry (wb_stall, wb_v, WB vectors)
// fed from ME; without it the scoreboard ends at ME.
// ----------------------------------------------------------------------------
module reg_scoreboard_gen
    import reg_sb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    reg_scoreboard_gen_if.slave  sb
);

    sb_entry_t ag_entry_s;
    sb_entry_t ex_q_s;
    sb_entry_t me_q_s;
    logic      ex_hold_s;

    // AG destination encode; an invalid AG slot yields an all-zero entry
    always_comb begin
        ag_entry_s = '0;
        if (sb.ag_v) begin
            ag_entry_s.v   = 1'b1;
            ag_entry_s.gpr = (sb.dr1_wr ? gpr_lane_encode(sb.dr1_id, sb.dr1_size) : 24'h000000)
                           | (sb.dr2_wr ? gpr_lane_encode(sb.dr2_id, sb.dr2_size) : 24'h000000);
            ag_entry_s.seg = sb.seg_wr ? reg_onehot8(sb.seg_id) : 8'h00;
            ag_entry_s.mm  = sb.mm_wr  ? reg_onehot8(sb.mm_id)  : 8'h00;
        end else begin
            ag_entry_s = '0;
        end
    end

    // An ME stall without an EX stall is illegal; EX is held anyway so that
    // no entry is overwritten while ME cannot accept it.
    assign ex_hold_s = sb.ex_stall | sb.me_stall;

    sb_stage_reg u_ex (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (sb.flush),
        .hold   (ex_hold_s),
        .bubble (1'b0),
        .d      (ag_entry_s),
        .q      (ex_q_s)
    );

    sb_stage_reg u_me (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (sb.flush),
        .hold   (sb.me_stall),
        .bubble (ex_hold_s),
        .d      (ex_q_s),
        .q      (me_q_s)
    );

    assign sb.ex_v              = ex_q_s.v;
    assign sb.ex_gpr_scoreboard = ex_q_s.gpr;
    assign sb.ex_seg_scoreboard = ex_q_s.seg;
    assign sb.ex_mm_scoreboard  = ex_q_s.mm;
    assign sb.me_v              = me_q_s.v;
    assign sb.me_gpr_scoreboard = me_q_s.gpr;
    assign sb.me_seg_scoreboard = me_q_s.seg;
    assign sb.me_mm_scoreboard  = me_q_s.mm;

`ifdef SB_WB_STAGE_EN
    sb_entry_t wb_q_s;

    sb_stage_reg u_wb (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (sb.flush),
        .hold   (sb.wb_stall),
        .bubble (sb.me_stall),
        .d      (me_q_s),
        .q      (wb_q_s)
    );

    assign sb.wb_v              = wb_q_s.v;
    assign sb.wb_gpr_scoreboard = wb_q_s.gpr;
    assign sb.wb_seg_scoreboard = wb_q_s.seg;
    assign sb.wb_mm_scoreboard  = wb_q_s.mm;
`endif

endmodule

// File: tb/tb_reg_scoreboard_gen.sv
// ----------------------------------------------------------------------------
// tb_reg_scoreboard_gen
// Directed self-checking bench for reg_scoreboard_gen (default build; the WB
// section runs only when SB_WB_STAGE_EN is defined).
// ----------------------------------------------------------------------------
module tb_reg_scoreboard_gen;

    logic       clk;
    logic       rst_n;
    logic [7:0] viol_cnt;
    int         check_cnt;
    int         fail_cnt;

    reg_scoreboard_gen_if sb_if ();

    reg_scoreboard_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb_if.slave)
    );

    reg_scoreboard_gen_chk #(.FATAL_ON_VIOLATION(1'b0)) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_stall (sb_if.ex_stall),
        .me_stall (sb_if.me_stall),
        .viol_cnt (viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt = check_cnt + 1;
        if (got !== exp) begin
            fail_cnt = fail_cnt + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ag();
        sb_if.ag_v     = 1'b0;
        sb_if.dr1_wr   = 1'b0;
        sb_if.dr1_id   = 3'd0;
        sb_if.dr1_size = 2'b00;
        sb_if.dr2_wr   = 1'b0;
        sb_if.dr2_id   = 3'd0;
        sb_if.dr2_size = 2'b00;
        sb_if.seg_wr   = 1'b0;
        sb_if.seg_id   = 3'd0;
        sb_if.mm_wr    = 1'b0;
        sb_if.mm_id    = 3'd0;
    endtask

    task automatic ag_dr1(input logic [2:0] id, input logic [1:0] size);
        clear_ag();
        sb_if.ag_v     = 1'b1;
        sb_if.dr1_wr   = 1'b1;
        sb_if.dr1_id   = id;
        sb_if.dr1_size = size;
    endtask

    initial begin
        check_cnt      = 0;
        fail_cnt       = 0;
        rst_n          = 1'b0;
        sb_if.flush    = 1'b0;
        sb_if.ex_stall = 1'b0;
        sb_if.me_stall = 1'b0;
`ifdef SB_WB_STAGE_EN
        sb_if.wb_stall = 1'b0;
`endif
        clear_ag();

        // Reset
        #12;
        check_val("rst_ex_v", 32'(sb_if.ex_v), 32'd0);
        check_val("rst_me_v", 32'(sb_if.me_v), 32'd0);
        check_val("rst_ex_gpr", 32'(sb_if.ex_gpr_scoreboard), 32'h0);
        check_val("rst_me_gpr", 32'(sb_if.me_gpr_scoreboard), 32'h0);
        rst_n = 1'b1;
        step();
        step();
        check_val("idle_ex_v", 32'(sb_if.ex_v), 32'd0);
        check_val("idle_me_v", 32'(sb_if.me_v), 32'd0);

        // Encode: id4 byte -> lane 1
        ag_dr1(3'd4, 2'b00);
        step();
        check_val("enc_byte_hi_gpr", 32'(sb_if.ex_gpr_scoreboard), 32'h000002);
        check_val("enc_byte_hi_v", 32'(sb_if.ex_v), 32'd1);
        // id2 dword + id0 word -> lanes 6,7,8,0,1
        ag_dr1(3'd2, 2'b10);
        sb_if.dr2_wr   = 1'b1;
        sb_if.dr2_id   = 3'd0;
        sb_if.dr2_size = 2'b01;
        step();
        check_val("enc_dual_gpr", 32'(sb_if.ex_gpr_scoreboard), 32'h0001C3);
        check_val("me_follow1_gpr", 32'(sb_if.me_gpr_scoreboard), 32'h000002);
        check_val("me_follow1_v", 32'(sb_if.me_v), 32'd1);
        clear_ag();
        step();
        check_val("me_follow2_gpr", 32'(sb_if.me_gpr_scoreboard), 32'h0001C3);
        check_val("ex_empty_v", 32'(sb_if.ex_v), 32'd0);
        check_val("ex_empty_gpr", 32'(sb_if.ex_gpr_scoreboard), 32'h0);

        // Stall / bubble: A = id1 word (0x18), B = id3 byte (0x200), C = id5 byte (0x10)
        ag_dr1(3'd1, 2'b01);
        step();
        ag_dr1(3'd3, 2'b00);
        step();
        check_val("stall_pre_ex", 32'(sb_if.ex_gpr_scoreboard), 32'h000200);
        check_val("stall_pre_me", 32'(sb_if.me_gpr_scoreboard), 32'h000018);
        ag_dr1(3'd5, 2'b00);
        sb_if.ex_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("stall_ex_hold", 32'(sb_if.ex_gpr_scoreboard), 32'h000200);
            check_val("stall_me_bubble_v", 32'(sb_if.me_v), 32'd0);
            check_val("stall_me_bubble_gpr", 32'(sb_if.me_gpr_scoreboard), 32'h0);
        end
        sb_if.ex_stall = 1'b0;
        clear_ag();
        step();
        check_val("resume_me_gpr", 32'(sb_if.me_gpr_scoreboard), 32'h000200);
        check_val("resume_me_v", 32'(sb_if.me_v), 32'd1);
        check_val("resume_ex_v", 32'(sb_if.ex_v), 32'd0);

        // Flush with SEG/MM entries in flight: D = id0 dword + seg3 + mm7, E = id7 word
        ag_dr1(3'd0, 2'b10);
        sb_if.seg_wr = 1'b1;
        sb_if.seg_id = 3'd3;
        sb_if.mm_wr  = 1'b1;
        sb_if.mm_id  = 3'd7;
        step();
        check_val("seg_ex", 32'(sb_if.ex_seg_scoreboard), 32'h08);
        check_val("mm_ex", 32'(sb_if.ex_mm_scoreboard), 32'h80);
        ag_dr1(3'd7, 2'b01);
        step();
        check_val("word_id7_ex", 32'(sb_if.ex_gpr_scoreboard), 32'h600000);
        check_val("seg_me", 32'(sb_if.me_seg_scoreboard), 32'h08);
        check_val("mm_me", 32'(sb_if.me_mm_scoreboard), 32'h80);
        check_val("gpr_me_d", 32'(sb_if.me_gpr_scoreboard), 32'h000007);
        sb_if.flush    = 1'b1;
        sb_if.ex_stall = 1'b1;
        sb_if.me_stall = 1'b1;
        step();
        check_val("flush_ex_v", 32'(sb_if.ex_v), 32'd0);
        check_val("flush_me_v", 32'(sb_if.me_v), 32'd0);
        check_val("flush_ex_gpr", 32'(sb_if.ex_gpr_scoreboard), 32'h0);
        check_val("flush_me_gpr", 32'(sb_if.me_gpr_scoreboard), 32'h0);
        check_val("flush_me_seg", 32'(sb_if.me_seg_scoreboard), 32'h0);
        check_val("flush_me_mm", 32'(sb_if.me_mm_scoreboard), 32'h0);
        sb_if.flush    = 1'b0;
        sb_if.ex_stall = 1'b0;
        sb_if.me_stall = 1'b0;

        // Illegal ME stall without EX stall: F = id6 byte (lane 7), G = id0 byte
        ag_dr1(3'd6, 2'b00);
        step();
        check_val("byte_id6_ex", 32'(sb_if.ex_gpr_scoreboard), 32'h000080);
        check_val("viol_none", 32'(viol_cnt), 32'd0);
        ag_dr1(3'd0, 2'b00);
        sb_if.me_stall = 1'b1;
        step();
        check_val("illegal_ex_hold", 32'(sb_if.ex_gpr_scoreboard), 32'h000080);
        check_val("illegal_me_v", 32'(sb_if.me_v), 32'd0);
        check_val("illegal_assert_fired", 32'(viol_cnt), 32'd1);
        sb_if.me_stall = 1'b0;
        clear_ag();
        step();
        check_val("illegal_after_me", 32'(sb_if.me_gpr_scoreboard), 32'h000080);

        // Reserved size and AG_V gating
        ag_dr1(3'd2, 2'b11);
        step();
        check_val("rsvd_ex_v", 32'(sb_if.ex_v), 32'd1);
        check_val("rsvd_ex_gpr", 32'(sb_if.ex_gpr_scoreboard), 32'h0);
        ag_dr1(3'd2, 2'b10);
        sb_if.ag_v = 1'b0;
        step();
        check_val("agv0_ex_v", 32'(sb_if.ex_v), 32'd0);
        check_val("agv0_ex_gpr", 32'(sb_if.ex_gpr_scoreboard), 32'h0);

        // Async reset mid-cycle clears without a clock edge
        ag_dr1(3'd0, 2'b10);
        step();
        check_val("pre_arst_ex", 32'(sb_if.ex_gpr_scoreboard), 32'h000007);
        clear_ag();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_ex_v", 32'(sb_if.ex_v), 32'd0);
        check_val("arst_ex_gpr", 32'(sb_if.ex_gpr_scoreboard), 32'h0);
        check_val("arst_me_gpr", 32'(sb_if.me_gpr_scoreboard), 32'h0);
        rst_n = 1'b1;
        ag_dr1(3'd1, 2'b10);
        step();
        check_val("post_arst_ex", 32'(sb_if.ex_gpr_scoreboard), 32'h000038);

`ifdef SB_WB_STAGE_EN
        // WB stage: entry H = id0 dword reaches WB 3 cycles after AG
        clear_ag();
        step();
        step();
        ag_dr1(3'd0, 2'b10);
        step();
        clear_ag();
        step();
        step();
        check_val("wb_arrive_gpr", 32'(sb_if.wb_gpr_scoreboard), 32'h000007);
        check_val("wb_arrive_v", 32'(sb_if.wb_v), 32'd1);
        sb_if.wb_stall = 1'b1;
        sb_if.me_stall = 1'b1;
        sb_if.ex_stall = 1'b1;
        step();
        check_val("wb_hold_gpr", 32'(sb_if.wb_gpr_scoreboard), 32'h000007);
        sb_if.wb_stall = 1'b0;
        step();
        check_val("wb_bubble_v", 32'(sb_if.wb_v), 32'd0);
        check_val("wb_bubble_gpr", 32'(sb_if.wb_gpr_scoreboard), 32'h0);
        sb_if.me_stall = 1'b0;
        sb_if.ex_stall = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
